// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, MMIO register
// offsets and STATUS bit positions.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [4:0] MMIO_GPIO       = 5'h00;
  localparam logic [4:0] MMIO_CYCLE_LO   = 5'h04;
  localparam logic [4:0] MMIO_CYCLE_HI   = 5'h08;
  localparam logic [4:0] MMIO_STATUS     = 5'h0C;
  localparam logic [4:0] MMIO_FAULT_ADDR = 5'h10;
  localparam logic [31:0] MMIO_SPAN      = 32'h14;

  localparam int unsigned STATUS_W    = 2;
  localparam int unsigned ST_MISALIGN = 0;
  localparam int unsigned ST_UNMAPPED = 1;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  // Unsupported func3 codes fall back to a word access.
  function automatic size_e size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic is_unsigned(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data,
// extended load data, and the alignment check for the addressed lane.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  size_e       size;
  logic        uns;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    size  = size_of(func3);
    uns   = is_unsigned(func3);
    rhalf = lane[1] ? rword[31:16] : rword[15:0];
    case (lane)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
  end

  // Store data is replicated across all lanes; the byte enables pick the target.
  always_comb begin
    be        = '0;
    wdata_sh  = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << lane;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = uns ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      SZ_H: begin
        misalign  = lane[0];
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = uns ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      default: begin
        misalign  = (lane != 2'b00);
        be        = 4'b1111;
        wdata_sh  = wdata;
        rdata_ext = rword;
      end
    endcase
    if (misalign) begin
      be        = '0;
      rdata_ext = '0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Zero-wait-state data memory: byte-enable RAM plus a small MMIO block
// (GPIO, 64-bit cycle counter, sticky fault status with first-fault address).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        mw_i,
  input  logic        mr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] rdata_o,
  output logic [31:0] gpio_o,
  output logic        fault_o
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam int unsigned RAM_BYTES = DEPTH_WORDS * 4;

  logic [31:0] mem [DEPTH_WORDS];

  logic [63:0]         cycle_q;
  logic [31:0]         hi_snap_q;
  logic [31:0]         gpio_q;
  logic [31:0]         fault_addr_q;
  logic [STATUS_W-1:0] status_q;

  logic                ram_hit;
  logic                mmio_hit;
  logic [31:0]         mmio_off;
  logic [4:0]          reg_off;
  logic [AW-1:0]       widx;
  logic [31:0]         mmio_rd;
  logic [31:0]         rword;
  logic [3:0]          be;
  logic [31:0]         wdata_sh;
  logic [31:0]         rdata_ext;
  logic                lane_misalign;

  logic                access;
  logic                is_store;
  logic                is_load;
  logic                misalign;
  logic                unmapped;
  logic                ok;
  logic                ram_we;
  logic                mmio_we;
  logic                mmio_re;
  logic [STATUS_W-1:0] status_set;
  logic [STATUS_W-1:0] status_clr;
  logic [STATUS_W-1:0] status_keep;
  logic                capture;

  // Address decode; RAM takes precedence if the windows ever overlap.
  always_comb begin
    ram_hit  = (addr_i < 32'(RAM_BYTES));
    mmio_off = addr_i - MMIO_BASE;
    mmio_hit = !ram_hit && (mmio_off < MMIO_SPAN);
    reg_off  = mmio_off[4:0];
    widx     = addr_i[AW+1:2];
  end

  always_comb begin
    mmio_rd = '0;
    case (reg_off)
      MMIO_GPIO:       mmio_rd = gpio_q;
      MMIO_CYCLE_LO:   mmio_rd = cycle_q[31:0];
      MMIO_CYCLE_HI:   mmio_rd = hi_snap_q;
      MMIO_STATUS:     mmio_rd = {{(32 - STATUS_W){1'b0}}, status_q};
      MMIO_FAULT_ADDR: mmio_rd = fault_addr_q;
      default:         mmio_rd = '0;
    endcase
    rword = ram_hit ? mem[widx] : mmio_rd;
  end

  dmem_lane_align u_lane_align (
    .func3     (func3_i),
    .lane      (addr_i[1:0]),
    .wdata     (wdata_i),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .misalign  (lane_misalign)
  );

  // Classify the request; a simultaneous store and load behaves as a store.
  always_comb begin
    access   = mw_i || mr_i;
    is_store = mw_i;
    is_load  = mr_i && !mw_i;
    misalign = access && (lane_misalign || (mmio_hit && (size_of(func3_i) != SZ_W)));
    unmapped = access && !misalign && !ram_hit && !mmio_hit;
    ok       = access && !misalign && !unmapped;
    ram_we   = is_store && ok && ram_hit && !rst_i;
    mmio_we  = is_store && ok && mmio_hit;
    mmio_re  = is_load && ok && mmio_hit;
    rdata_o  = (is_load && ok) ? rdata_ext : 32'h0;
  end

  // New faults win over a same-cycle W1C; the address latches only from a clean status.
  always_comb begin
    status_set              = '0;
    status_set[ST_MISALIGN] = misalign;
    status_set[ST_UNMAPPED] = unmapped;
    status_clr              = '0;
    if (mmio_we && (reg_off == MMIO_STATUS)) begin
      status_clr = wdata_i[STATUS_W-1:0];
    end
    status_keep = status_q & ~status_clr;
    capture     = (status_set != '0) && (status_keep == '0);
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cycle_q      <= '0;
      hi_snap_q    <= '0;
      gpio_q       <= '0;
      fault_addr_q <= '0;
      status_q     <= '0;
    end else begin
      cycle_q  <= cycle_q + 64'd1;
      status_q <= status_keep | status_set;
      if (mmio_re && (reg_off == MMIO_CYCLE_LO)) begin
        hi_snap_q <= cycle_q[63:32];
      end
      if (mmio_we && (reg_off == MMIO_GPIO)) begin
        gpio_q <= wdata_i;
      end
      if (capture) begin
        fault_addr_q <= addr_i;
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[widx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
        end
      end
    end
  end

  assign gpio_o  = gpio_q;
  assign fault_o = |status_q;

endmodule
